// File: rtl/inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : inv_key_sched
//  Purpose  : AES-128 inverse key schedule. Starting from the round-10 key,
//             produces the decryption-order round keys K10, K9 ... K0, one
//             key per accepted beat, by running the key expansion backwards.
//  Ports    : clk      - rising-edge clock
//             rst      - synchronous active-high reset
//             start    - begin an expansion (sampled only while idle)
//             key_in   - round-10 key, word 0 in bits 0:31, MSB first
//             busy     - high whenever a run is in progress
//             rk_valid - rk_out / rk_idx carry a valid round key
//             rk_out   - current round key, same ordering as key_in
//             rk_idx   - round number of rk_out, 10 down to 0
//             done     - high on the rk_idx = 0 beat
//             rk_ready - consumer accepts the beat (ROUND_KEY_STALL_EN only)
//  Config   : ROUND_KEY_STALL_EN - adds rk_ready back-pressure; when
//             undefined every valid beat is taken as accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
`ifdef ROUND_KEY_STALL_EN
    ,
    input  logic         rk_ready
`endif
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_last = 2'd2;

    logic [1:0]   r_state;
    logic         r_busy;
    logic         r_valid;
    logic         r_done;
    logic [0:127] r_rk;
    logic [3:0]   r_idx;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic         w_accept;

`ifdef ROUND_KEY_STALL_EN
    assign w_accept = r_valid & rk_ready;
`else
    assign w_accept = r_valid;
`endif

    // Word 0 occupies the lowest-numbered bits; its MSB is bit 0.
    assign w_w0 = r_rk[0:31];
    assign w_w1 = r_rk[32:63];
    assign w_w2 = r_rk[64:95];
    assign w_w3 = r_rk[96:127];

    // Undo the forward expansion: the previous round's last three words are
    // XOR differences of adjacent words, and the first word strips the
    // g-function, which is applied to the recovered previous word 3.
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_p0 = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // Round constant used to derive round (idx) from round (idx - 1).
    always_comb begin
        w_rcon = 8'h00;
        case (r_idx)
            4'd10:   w_rcon = 8'h36;
            4'd9:    w_rcon = 8'h1b;
            4'd8:    w_rcon = 8'h80;
            4'd7:    w_rcon = 8'h40;
            4'd6:    w_rcon = 8'h20;
            4'd5:    w_rcon = 8'h10;
            4'd4:    w_rcon = 8'h08;
            4'd3:    w_rcon = 8'h04;
            4'd2:    w_rcon = 8'h02;
            4'd1:    w_rcon = 8'h01;
            default: w_rcon = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_rk    <= '0;
            r_idx   <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_run;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_done  <= 1'b0;
                        r_rk    <= key_in;
                        r_idx   <= 4'd10;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        r_rk  <= {w_p0, w_p1, w_p2, w_p3};
                        r_idx <= r_idx - 4'd1;
                        // Loading K0 moves to the final, done-flagged beat.
                        if (r_idx == 4'd1) begin
                            r_state <= c_st_last;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_st_last: begin
                    // rk_out keeps K0 while idle; only the flags drop.
                    if (w_accept) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign rk_valid = r_valid;
    assign rk_out   = r_rk;
    assign rk_idx   = r_idx;
    assign done     = r_done;

endmodule

// ============================================================================
//  Module   : sbox
//  Purpose  : AES forward S-box, one byte in, one byte out (combinational).
//  Ports    : i_byte - input byte
//             o_byte - substituted byte
//  Revision : 1.0 - initial release
// ============================================================================
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 is the most significant byte of the table.
    localparam logic [0:255][7:0] c_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_table[i_byte];

endmodule
`default_nettype wire

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 The module SHALL have the port: clk  input  1  single rising-edge clock for all state.
REQ-002 The module SHALL have the port: rst  input  1  reset, synchronous to clk and active-high.
REQ-003 The module SHALL have the port: start  input  1  request to begin an expansion; sampled only in IDLE.
REQ-004 The module SHALL have the port: key_in  input  [0:127]  AES-128 round-10 key; bits 0:31 are word 0, MSB first.
REQ-005 The module SHALL have the port: busy  output  1  high in every state except IDLE.
REQ-006 The module SHALL have the port: rk_valid  output  1  rk_out and rk_idx hold a valid round key.
REQ-007 The module SHALL have the port: rk_out  output  [0:127]  current round key, in the same word/bit ordering as key_in.
REQ-008 The module SHALL have the port: rk_idx  output  [3:0]  round number of rk_out, counting down 10 to 0.
REQ-009 The module SHALL have the port: done  output  1  one-cycle pulse, coincident with the rk_idx=0 beat.
REQ-010 When ROUND_KEY_STALL_EN is defined, the module SHALL have the port: rk_ready  input  1  consumer accepts the current beat.

Function
REQ-011 The module SHALL produce the decryption-order round keys K10, K9, ... K0 from K10, one key per accepted beat.
REQ-012 The FSM SHALL have three states: IDLE, RUN, LAST.
REQ-013 IDLE->RUN SHALL occur on start=1; on the same edge key_in is registered into rk_out and rk_idx is set to 10.
REQ-014 key_in SHALL be sampled only on the start edge; later changes to key_in SHALL have no effect on the current run.
REQ-015 In RUN and LAST, rk_valid SHALL be 1; the first beat (K10, idx 10) SHALL appear in the cycle after start.
REQ-016 The inverse step for current words w0..w3 and round idx SHALL compute p3=w3^w2, p2=w2^w1, p1=w1^w0, and p0=w0^SubWord(RotWord(p3))^rcon(idx).
REQ-017 rcon(idx) for idx 10..1 SHALL be 36,1b,80,40,20,10,08,04,02,01 (hex), in byte 0 of the word with the other bytes zero.
REQ-018 SubWord SHALL use four instances of the existing sbox block.
REQ-019 RotWord SHALL be a left rotation by one byte.
REQ-020 On each accepted beat with rk_idx>1, rk_out SHALL load p0..p3 and rk_idx SHALL decrement by 1.
REQ-021 When rk_idx decrements to 0, the state SHALL go RUN->LAST.
REQ-022 In LAST, done SHALL be 1 and rk_idx SHALL be 0; when that beat is accepted, the state SHALL return to IDLE and rk_valid SHALL fall.
REQ-023 Latency SHALL be 1 cycle from start to the first beat; with no stall, done SHALL occur 11 cycles after start.
REQ-024 start SHALL be ignored while busy=1; there is no queuing.
REQ-025 start=1 in the cycle busy falls SHALL be ignored; start SHALL be accepted only while state=IDLE.
REQ-026 rk_idx SHALL never wrap below 0 and SHALL never exceed 10.
REQ-027 In IDLE, rk_out SHALL hold its last value; it is not required to be cleared.

Reset
REQ-028 On rst=1 at a clock edge, the state SHALL be IDLE, busy=0, rk_valid=0, done=0, rk_idx=0, rk_out=0.
REQ-029 rst SHALL override start and any in-progress run, aborting mid-expansion with no further beats.
REQ-030 While rst is held high, all outputs SHALL remain at their reset values.

Configuration
REQ-031 The block SHALL support the macro ROUND_KEY_STALL_EN.
REQ-032 With ROUND_KEY_STALL_EN defined, a beat SHALL be accepted when rk_valid&rk_ready; otherwise rk_out, rk_idx, done and the state SHALL hold unchanged.
REQ-033 Without ROUND_KEY_STALL_EN, the rk_ready port SHALL be absent and every rk_valid cycle SHALL be treated as accepted, with the consumer required to take one key per cycle.

Verification
REQ-034 The bench SHALL cover: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 -> idx10=d014f9a8c9ee2589e13f0cc8b6630ca6, idx9=ac7766f319fadc2128d12941575c006e, idx1=a0fafe1788542cb123a339392a6c7605, and idx0=2b7e151628aed2a6abf7158809cf4f3c with done=1 at cycle 11.
REQ-035 The bench SHALL cover: start pulsed again at cycles 3 and 7 of a run -> ignored, with the key sequence identical to REQ-034.
REQ-036 The bench SHALL cover: rst asserted at idx=5 -> next cycle busy=0, rk_valid=0, rk_out=0, with no done pulse; a fresh start then yields the full sequence from idx 10.
REQ-037 The bench SHALL cover: start held high continuously -> back-to-back runs separated by exactly one IDLE cycle, with done once per run.
REQ-038 With ROUND_KEY_STALL_EN defined, the bench SHALL cover: rk_ready low for 3 cycles at idx 9 and for 2 cycles in LAST -> outputs stable during the stalls, done held until accepted, and 16 cycles total from start to IDLE.
REQ-039 The bench SHALL cover: key_in changed during a run -> the output sequence is unaffected.
